// File: rtl/qam_tx_out_buffer.sv
// Output buffer for the 16-QAM transmit chain: drops start-up samples,
// scales/saturates to DAC width, and buffers into a valid/ready FIFO.
module qam_tx_out_buffer #(
    parameter int unsigned IN_W  = 65,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SKIP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_pulse,
    output logic                     overflow,
    output logic                     warm
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned CNT_W = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Skip / warm-up state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             warm_q, warm_d;

    // Stage 1 registers
    logic [OUT_W-1:0] s1_data_q, s1_data_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_clip_q, s1_clip_d;

    // FIFO state
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    logic signed [IN_W-1:0] scaled_c;
    logic                   pos_clip_c;
    logic                   neg_clip_c;
    logic                   full_c;
    logic                   pop_c;
    logic                   wr_en_c;
    logic                   skip_last_c;

    // Scale, saturate and track warm-up; compute next-state for all flops
    always_comb begin
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        s1_data_d   = s1_data_q;
        s1_valid_d  = 1'b0;
        s1_clip_d   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;

        scaled_c    = $signed(in_data) >>> SHIFT;
        // Out of range when the bits above the output sign differ from the sign
        pos_clip_c  = !scaled_c[IN_W-1] && (|scaled_c[IN_W-2:OUT_W-1]);
        neg_clip_c  = scaled_c[IN_W-1] && !(&scaled_c[IN_W-2:OUT_W-1]);
        skip_last_c = (SKIP != 0) && (cnt_q == CNT_W'(SKIP - 1));

        full_c  = (level_q == LVL_W'(DEPTH));
        pop_c   = (level_q != '0) && out_ready;
        wr_en_c = s1_valid_q && (!full_c || pop_c);

        // Warm-up: discard samples; warm rises together with the final count
        if (in_valid && !warm_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (skip_last_c) begin
                warm_d = 1'b1;
            end
        end

        if (in_valid && warm_q) begin
            s1_valid_d = 1'b1;
            s1_clip_d  = pos_clip_c || neg_clip_c;
            if (pos_clip_c) begin
                s1_data_d = POS_MAX;
            end else if (neg_clip_c) begin
                s1_data_d = NEG_MIN;
            end else begin
                s1_data_d = scaled_c[OUT_W-1:0];
            end
        end

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!wr_en_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
        end
        if (s1_valid_q && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            warm_q     <= (SKIP == 0);
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_clip_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            warm_q     <= warm_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_clip_q  <= s1_clip_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are qualified by level so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign sat_pulse = s1_clip_q;
    assign overflow  = overflow_q;
    assign warm      = warm_q;

endmodule

// File: tb/tb_qam_tx_out_buffer.sv
// Directed bench for qam_tx_out_buffer with hand-computed expectations.
module tb_qam_tx_out_buffer;

    logic               clk;
    logic               reset;
    logic signed [64:0] in_data;
    logic               in_valid;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         level;
    logic               sat_pulse;
    logic               overflow;
    logic               warm;

    int n_checks;
    int n_fail;

    qam_tx_out_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .sat_pulse (sat_pulse),
        .overflow  (overflow),
        .warm      (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [64:0] smp(input longint k);
        logic signed [64:0] v;
        v = 65'(k);
        return v <<< 32;
    endfunction

    // Push one post-warm sample, check clip flag and output, then pop it
    task automatic send_one(input logic signed [64:0] d, input longint exp_out, input longint exp_sat);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        check("sat_pulse", longint'(sat_pulse), exp_sat);
        step();
        check("sat_pulse_clear", longint'(sat_pulse), 0);
        check("sat_out_data", longint'(out_data), exp_out);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("sat_drained", longint'(level), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_level", longint'(level), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_warm", longint'(warm), 0);
        check("rst_sat", longint'(sat_pulse), 0);

        // Warm-up: samples 1..4 discarded, 5 and 6 kept
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            in_data  = smp(k);
            step();
            if (k == 3) check("warm_before", longint'(warm), 0);
            if (k == 4) check("warm_after4", longint'(warm), 1);
            if (k == 4) check("skip_level", longint'(level), 0);
        end
        in_valid = 1'b0;
        step();
        check("warm_level_peak", longint'(level), 2);
        check("warm_head5", longint'(out_data), 5);
        out_ready = 1'b1;
        step();
        check("warm_head6", longint'(out_data), 6);
        step();
        check("warm_empty", longint'(out_valid), 0);
        out_ready = 1'b0;

        // Saturation cases
        send_one(smp(65536), 32767, 1);
        send_one(-smp(262144), -32768, 1);
        send_one(-smp(2), -2, 0);

        // Overflow: 20 samples with no consumer
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = smp(k);
            step();
            if (k == 16) begin
                check("ovf_level16", longint'(level), 16);
                check("ovf_not_yet", longint'(overflow), 0);
            end
            if (k == 17) check("ovf_set", longint'(overflow), 1);
        end
        in_valid = 1'b0;
        step();
        check("ovf_level_hold", longint'(level), 16);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("ovf_drain_data", longint'(out_data), j);
            step();
        end
        out_ready = 1'b0;
        check("ovf_drained_valid", longint'(out_valid), 0);
        check("ovf_sticky", longint'(overflow), 1);

        // Reset mid-operation with samples buffered and in flight
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = smp(k + 40);
            step();
        end
        check("mid_level9", longint'(level), 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_level", longint'(level), 0);
        check("mid_out_valid", longint'(out_valid), 0);
        check("mid_overflow", longint'(overflow), 0);
        check("mid_warm", longint'(warm), 0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = smp(k + 60);
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_reskip_level", longint'(level), 0);
        check("mid_rewarm", longint'(warm), 1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i <= 26; i++) begin
            in_valid  = (i <= 25);
            in_data   = smp(100 + i);
            out_ready = (i >= 17);
            step();
            if (i >= 16) begin
                check("full_level", longint'(level), 16);
                check("full_head", longint'(out_data), 100 + (i - 16));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_no_ovf", longint'(overflow), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("full_drain", longint'(out_data), 110 + j);
            step();
        end
        check("full_empty", longint'(out_valid), 0);

        // Latency: empty FIFO, consumer ready
        in_valid = 1'b1;
        in_data  = smp(7);
        step();
        in_valid = 1'b0;
        check("lat_not_yet", longint'(out_valid), 0);
        step();
        check("lat_valid", longint'(out_valid), 1);
        check("lat_data", longint'(out_data), 7);
        check("lat_level", longint'(level), 1);
        step();
        check("lat_gone", longint'(out_valid), 0);
        check("lat_level0", longint'(level), 0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
